// File: rtl/tight_acc_reduce_pkg.sv
// tight_acc_pkg: opcodes, FSM encoding and bus widths shared by the tight_acc_reduce slice.
package tight_acc_pkg;

    localparam int OPCODE_W              = 6;
    localparam int TRANSID_W             = 6;
    localparam int DCP_PADDR             = 40;
    localparam int DCP_NOC_RES_DATA_SIZE = 64;

    typedef enum logic [OPCODE_W-1:0] {
        OP_SET_BASE    = 6'd0,
        OP_SET_STRIDE  = 6'd1,
        OP_SET_COUNT   = 6'd2,
        OP_START       = 6'd3,
        OP_READ_COUNT  = 6'd4,
        OP_READ_CYCLES = 6'd5
    } opcode_e;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_RESP  = 2'd3;

endpackage

// File: rtl/tight_acc_reduce_if.sv
// tight_acc_reduce_if: command, result and L2 load channels of the reduction accelerator.
// slave = accelerator side, master = core/memory side.
interface tight_acc_reduce_if;
    import tight_acc_pkg::*;

    logic                             cmd_val;
    logic                             busy;
    logic [OPCODE_W-1:0]              cmd_opcode;
    logic [63:0]                      cmd_config_data;

    logic                             resp_val;
    logic                             resp_rdy;
    logic [63:0]                      resp_data;

    logic                             mem_req_rdy;
    logic                             mem_req_val;
    logic [TRANSID_W-1:0]             mem_req_transid;
    logic [DCP_PADDR-1:0]             mem_req_addr;

    logic                             mem_resp_val;
    logic [TRANSID_W-1:0]             mem_resp_transid;
    logic [DCP_NOC_RES_DATA_SIZE-1:0] mem_resp_data;

    modport slave (
        input  cmd_val, cmd_opcode, cmd_config_data, resp_rdy, mem_req_rdy,
        input  mem_resp_val, mem_resp_transid, mem_resp_data,
        output busy, resp_val, resp_data, mem_req_val, mem_req_transid, mem_req_addr
    );

    modport master (
        output cmd_val, cmd_opcode, cmd_config_data, resp_rdy, mem_req_rdy,
        output mem_resp_val, mem_resp_transid, mem_resp_data,
        input  busy, resp_val, resp_data, mem_req_val, mem_req_transid, mem_req_addr
    );

endinterface

// File: rtl/tight_acc_txn_tracker.sv
// tight_acc_txn_tracker: per-slot outstanding bitmap plus occupancy count and flags.
module tight_acc_txn_tracker
    import tight_acc_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = 8,
    localparam int unsigned CW          = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en,
    input  logic [TRANSID_W-1:0] set_id,
    input  logic                 resp_val,
    input  logic [TRANSID_W-1:0] resp_id,
    output logic                 slot_busy,
    output logic                 resp_hit,
    output logic                 full,
    output logic                 empty,
    output logic                 empty_next
);
    logic [MAX_INFLIGHT-1:0] bitmap_q, bitmap_d, set_mask, resp_mask;
    logic [CW-1:0]           count_q, count_d;

    // Decode ids to slot masks; ids beyond MAX_INFLIGHT decode to nothing and are ignored.
    always_comb begin
        set_mask  = '0;
        resp_mask = '0;
        for (int i = 0; i < MAX_INFLIGHT; i++) begin
            set_mask[i]  = (set_id == TRANSID_W'(i));
            resp_mask[i] = (resp_id == TRANSID_W'(i));
        end
    end

    assign slot_busy = |(bitmap_q & set_mask);
    assign resp_hit  = resp_val && |(bitmap_q & resp_mask);

    // Set and clear never target the same slot: the issuer waits for a free slot.
    always_comb begin
        bitmap_d = bitmap_q;
        if (set_en) begin
            bitmap_d = bitmap_d | set_mask;
        end
        if (resp_hit) begin
            bitmap_d = bitmap_d & ~resp_mask;
        end
        count_d = count_q + CW'(set_en) - CW'(resp_hit);
    end

    // Outstanding state; reset drops any in-flight marks so late responses are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitmap_q <= '0;
            count_q  <= '0;
        end else begin
            bitmap_q <= bitmap_d;
            count_q  <= count_d;
        end
    end

    assign full       = (count_q == CW'(MAX_INFLIGHT));
    assign empty      = (count_q == '0);
    assign empty_next = (count_d == '0);

endmodule

// File: rtl/tight_acc_reduce.sv
// tight_acc_reduce: issues COUNT 64-bit loads at base + i*stride and returns their 64-bit sum.
// Define TIGHT_ACC_REDUCE_PERF_EN to add a 32-bit ISSUE/DRAIN cycle counter read by
// opcode READ_CYCLES; without it opcode 5 is ignored like any unknown opcode.
module tight_acc_reduce
    import tight_acc_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = 8,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    tight_acc_reduce_if.slave bus
);
    state_t               state_q, state_d;
    logic [DCP_PADDR-1:0] base_q, addr_q;
    logic [63:0]          stride_q, sum_q, sum_d, resp_data_q;
    logic [CNT_W-1:0]     count_q, idx_q;
    logic [31:0]          idx_ext;
    logic [TRANSID_W-1:0] issue_id;
    logic                 cmd_acc, start_acc, req_val, req_fire, last_issue;
    logic                 slot_busy, resp_hit, trk_full, trk_empty, trk_empty_next;
    logic                 unused_bits;
`ifdef TIGHT_ACC_REDUCE_PERF_EN
    logic [31:0]          cycles_q;
`endif

    assign cmd_acc    = bus.cmd_val && (state_q == ST_IDLE);
    assign start_acc  = cmd_acc && (bus.cmd_opcode == OP_START);
    assign idx_ext    = 32'(idx_q);
    assign issue_id   = TRANSID_W'(idx_ext % MAX_INFLIGHT);
    // Slot check keeps a reused transid from colliding with a still-outstanding one.
    assign req_val    = (state_q == ST_ISSUE) && !trk_full && !slot_busy;
    assign req_fire   = req_val && bus.mem_req_rdy;
    assign last_issue = (idx_q == count_q - CNT_W'(1));

    tight_acc_txn_tracker #(
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .set_en     (req_fire),
        .set_id     (issue_id),
        .resp_val   (bus.mem_resp_val),
        .resp_id    (bus.mem_resp_transid),
        .slot_busy  (slot_busy),
        .resp_hit   (resp_hit),
        .full       (trk_full),
        .empty      (trk_empty),
        .empty_next (trk_empty_next)
    );

    // Running sum: cleared by START, accumulates each tracked response (wraps mod 2^64).
    always_comb begin
        sum_d = sum_q;
        if (start_acc) begin
            sum_d = '0;
        end else if (resp_hit) begin
            sum_d = sum_q + bus.mem_resp_data[63:0];
        end
    end

    // Job sequencing; DRAIN exits on the cycle the last response lands to save a cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_acc) begin
                    if (bus.cmd_opcode == OP_START) begin
                        state_d = (count_q == '0) ? ST_RESP : ST_ISSUE;
                    end else if (bus.cmd_opcode == OP_READ_COUNT) begin
                        state_d = ST_RESP;
                    end
`ifdef TIGHT_ACC_REDUCE_PERF_EN
                    else if (bus.cmd_opcode == OP_READ_CYCLES) begin
                        state_d = ST_RESP;
                    end
`endif
                end
            end
            ST_ISSUE: if (req_fire && last_issue) state_d = ST_DRAIN;
            ST_DRAIN: if (trk_empty_next) state_d = ST_RESP;
            ST_RESP:  if (bus.resp_rdy) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Config registers, issue pointer, sum and the held response word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            stride_q    <= '0;
            count_q     <= '0;
            addr_q      <= '0;
            idx_q       <= '0;
            sum_q       <= '0;
            resp_data_q <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            if (cmd_acc) begin
                case (bus.cmd_opcode)
                    OP_SET_BASE:   base_q   <= bus.cmd_config_data[DCP_PADDR-1:0];
                    OP_SET_STRIDE: stride_q <= bus.cmd_config_data;
                    OP_SET_COUNT:  count_q  <= bus.cmd_config_data[CNT_W-1:0];
                    OP_START: begin
                        addr_q <= base_q;
                        idx_q  <= '0;
                        if (count_q == '0) resp_data_q <= '0;
                    end
                    OP_READ_COUNT: resp_data_q <= 64'(count_q);
`ifdef TIGHT_ACC_REDUCE_PERF_EN
                    OP_READ_CYCLES: resp_data_q <= 64'(cycles_q);
`endif
                    default: ;
                endcase
            end
            if (req_fire) begin
                addr_q <= addr_q + stride_q[DCP_PADDR-1:0];
                idx_q  <= idx_q + CNT_W'(1);
            end
            if ((state_q == ST_DRAIN) && trk_empty_next) begin
                resp_data_q <= sum_d;
            end
        end
    end

`ifdef TIGHT_ACC_REDUCE_PERF_EN
    // Counts ISSUE/DRAIN cycles of the most recent job.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycles_q <= '0;
        end else if (start_acc) begin
            cycles_q <= '0;
        end else if ((state_q == ST_ISSUE) || (state_q == ST_DRAIN)) begin
            cycles_q <= cycles_q + 32'd1;
        end
    end
`endif

    // Stride bits above the address width cannot affect a wrapped address.
    assign unused_bits = ^{stride_q[63:DCP_PADDR], trk_empty};

    assign bus.busy            = (state_q != ST_IDLE);
    assign bus.resp_val        = (state_q == ST_RESP);
    assign bus.resp_data       = resp_data_q;
    assign bus.mem_req_val     = req_val;
    assign bus.mem_req_transid = issue_id;
    assign bus.mem_req_addr    = addr_q;

endmodule

// File: tb/tb_tight_acc_reduce.sv
// tb_tight_acc_reduce: directed scoreboard bench for tight_acc_reduce (MAX_INFLIGHT = 2).
`timescale 1ns/1ps
module tb_tight_acc_reduce;
    import tight_acc_pkg::*;

    localparam int unsigned NINF = 2;

    typedef struct {
        logic [5:0]  id;
        logic [63:0] data;
    } pend_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tight_acc_reduce_if bus ();

    tight_acc_reduce #(
        .MAX_INFLIGHT (NINF),
        .CNT_W        (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pend_t                pend[$];
    pend_t                inj_q[$];
    logic [63:0]          data_q[$];
    logic [63:0]          exp_resp_q[$];
    logic [DCP_PADDR-1:0] exp_addr_q[$];
    int                   mem_mode = 0;  // 0 FIFO replies, 1 hold, 2 reply newest first
    int                   errors = 0;
    int                   checks = 0;
    int                   n_issued = 0;
    int                   max_pend = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic inject(input logic [5:0] id, input logic [63:0] d);
        pend_t p;
        p.id   = id;
        p.data = d;
        inj_q.push_back(p);
    endtask

    task automatic do_cmd(input logic [5:0] op, input logic [63:0] d);
        int n = 0;
        bus.cmd_val         = 1'b1;
        bus.cmd_opcode      = op;
        bus.cmd_config_data = d;
        @(negedge clk);
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) timeout("cmd_accept");
        @(posedge clk);
        #1;
        bus.cmd_val = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((bus.busy || exp_resp_q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) timeout(name);
        @(posedge clk);
        #1;
    endtask

    task automatic cycles_to_resp(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.resp_val && k < 100);
    endtask

    // Request capture: checks each issued address and binds it to the next data word.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.mem_req_val && bus.mem_req_rdy) begin
                pend_t                p;
                logic [DCP_PADDR-1:0] ea;
                ea = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 'x;
                check("mem_req_addr", 64'(bus.mem_req_addr), 64'(ea));
                p.id   = bus.mem_req_transid;
                p.data = (data_q.size() != 0) ? data_q.pop_front() : 64'hdead;
                pend.push_back(p);
                n_issued++;
                if (pend.size() > max_pend) max_pend = pend.size();
            end
        end
    end

    // Memory responder: injected beats first, then replies according to mem_mode.
    initial begin
        bus.mem_resp_val     = 1'b0;
        bus.mem_resp_transid = '0;
        bus.mem_resp_data    = '0;
        forever begin
            pend_t p;
            logic  go;
            @(posedge clk);
            #1;
            go = 1'b0;
            if (inj_q.size() != 0) begin
                p  = inj_q.pop_front();
                go = 1'b1;
            end else if (mem_mode == 0 && pend.size() != 0) begin
                p  = pend.pop_front();
                go = 1'b1;
            end else if (mem_mode == 2 && pend.size() != 0) begin
                p  = pend.pop_back();
                go = 1'b1;
            end
            bus.mem_resp_val = go;
            if (go) begin
                bus.mem_resp_transid = p.id;
                bus.mem_resp_data    = p.data;
            end
        end
    end

    // Result monitor: every completed result handshake pops one expected value.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.resp_val && bus.resp_rdy) begin
                logic [63:0] e;
                e = (exp_resp_q.size() != 0) ? exp_resp_q.pop_front() : 'x;
                check("resp_data", bus.resp_data, e);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int snap;
        pend_t p;
        rst                 = 1'b1;
        bus.cmd_val         = 1'b0;
        bus.cmd_opcode      = '0;
        bus.cmd_config_data = '0;
        bus.resp_rdy        = 1'b1;
        bus.mem_req_rdy     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_resp_val", 64'(bus.resp_val), 64'd0);
        check("rst_resp_data", bus.resp_data, 64'd0);
        check("rst_mem_req_val", 64'(bus.mem_req_val), 64'd0);
        check("rst_transid", 64'(bus.mem_req_transid), 64'd0);
        check("rst_addr", 64'(bus.mem_req_addr), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic in-order job: 1+2+3+4.
        data_q     = '{64'd1, 64'd2, 64'd3, 64'd4};
        exp_addr_q = '{40'h1000, 40'h1008, 40'h1010, 40'h1018};
        exp_resp_q.push_back(64'd10);
        do_cmd(OP_SET_BASE, 64'h1000);
        do_cmd(OP_SET_STRIDE, 64'd8);
        do_cmd(OP_SET_COUNT, 64'd4);
        do_cmd(OP_START, 64'd0);
        wait_done("basic_job");
        check("basic_addrs_left", 64'(exp_addr_q.size()), 64'd0);

        // Single element, zero-wait memory: result three cycles after START.
        data_q.push_back(64'h55);
        exp_addr_q.push_back(40'h1000);
        exp_resp_q.push_back(64'h55);
        do_cmd(OP_SET_COUNT, 64'd1);
        do_cmd(OP_START, 64'd0);
        cycles_to_resp(k);
        check("latency_count1", 64'(k), 64'd3);
        wait_done("count1_job");

        // Zero count: immediate zero result, no loads.
        snap = n_issued;
        exp_resp_q.push_back(64'd0);
        do_cmd(OP_SET_COUNT, 64'd0);
        do_cmd(OP_START, 64'd0);
        cycles_to_resp(k);
        check("latency_count0", 64'(k), 64'd1);
        wait_done("count0_job");
        check("count0_no_loads", 64'(n_issued - snap), 64'd0);

        // Withheld responses: at most NINF outstanding, then released newest first.
        mem_mode   = 1;
        max_pend   = 0;
        data_q     = '{64'd10, 64'd20, 64'd30, 64'd40, 64'd50};
        exp_addr_q = '{40'h1000, 40'h1008, 40'h1010, 40'h1018, 40'h1020};
        exp_resp_q.push_back(64'd150);
        do_cmd(OP_SET_COUNT, 64'd5);
        do_cmd(OP_START, 64'd0);
        repeat (8) @(negedge clk);
        check("full_req_val_low", 64'(bus.mem_req_val), 64'd0);
        check("held_outstanding", 64'(pend.size()), 64'd2);
        mem_mode = 2;
        wait_done("reverse_job");
        check("max_outstanding", 64'(max_pend), 64'd2);
        mem_mode = 1;

        // Stray responses in IDLE, duplicate during job, result held under back-pressure.
        inject(6'd7, 64'h1000);
        inject(6'd1, 64'h2000);
        repeat (3) @(posedge clk);
        #1;
        data_q     = '{64'd5, 64'd6};
        exp_addr_q = '{40'h1000, 40'h1008};
        exp_resp_q.push_back(64'd11);
        bus.resp_rdy = 1'b0;
        do_cmd(OP_SET_COUNT, 64'd2);
        do_cmd(OP_START, 64'd0);
        repeat (4) @(negedge clk);
        check("dup_outstanding", 64'(pend.size()), 64'd2);
        p = pend.pop_back();
        inject(p.id, p.data);
        inject(p.id, 64'h100);
        p = pend.pop_front();
        inject(p.id, p.data);
        cycles_to_resp(k);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_resp_val", 64'(bus.resp_val), 64'd1);
            check("stall_resp_data", bus.resp_data, 64'd11);
        end
        @(posedge clk);
        #1;
        bus.resp_rdy = 1'b1;
        wait_done("dup_job");
        mem_mode = 0;

        // Address wrap at the physical address width; stride bit 40 has no effect.
        data_q     = '{64'd1, 64'd2, 64'd3};
        exp_addr_q = '{40'hff_ffff_fff8, 40'h00_0000_0008, 40'h00_0000_0018};
        exp_resp_q.push_back(64'd6);
        do_cmd(OP_SET_BASE, 64'h0000_00ff_ffff_fff8);
        do_cmd(OP_SET_STRIDE, 64'h0000_0100_0000_0010);
        do_cmd(OP_SET_COUNT, 64'd3);
        do_cmd(OP_START, 64'd0);
        wait_done("wrap_job");
        check("wrap_addrs_left", 64'(exp_addr_q.size()), 64'd0);

        // READ_COUNT returns only the low CNT_W bits.
        exp_resp_q.push_back(64'h1234);
        do_cmd(OP_SET_COUNT, 64'hffff_1234);
        do_cmd(OP_READ_COUNT, 64'd0);
        wait_done("read_count");

        // Unknown opcode is accepted and ignored.
        do_cmd(6'd9, 64'd0);
        repeat (3) @(negedge clk);
        check("op9_busy", 64'(bus.busy), 64'd0);
        check("op9_resp_val", 64'(bus.resp_val), 64'd0);

`ifdef TIGHT_ACC_REDUCE_PERF_EN
        // Two elements, request channel stalled for three cycles: 5 ISSUE + 1 DRAIN.
        data_q     = '{64'd1, 64'd1};
        exp_addr_q = '{40'h1000, 40'h1008};
        exp_resp_q.push_back(64'd2);
        do_cmd(OP_SET_BASE, 64'h1000);
        do_cmd(OP_SET_STRIDE, 64'd8);
        do_cmd(OP_SET_COUNT, 64'd2);
        bus.mem_req_rdy = 1'b0;
        do_cmd(OP_START, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        bus.mem_req_rdy = 1'b1;
        wait_done("perf_job");
        exp_resp_q.push_back(64'd6);
        do_cmd(OP_READ_CYCLES, 64'd0);
        wait_done("read_cycles");
`else
        do_cmd(6'd5, 64'd0);
        repeat (3) @(negedge clk);
        check("op5_busy", 64'(bus.busy), 64'd0);
        check("op5_resp_val", 64'(bus.resp_val), 64'd0);
`endif

        // Reset in DRAIN with loads outstanding; late responses must be dropped.
        mem_mode = 1;
        data_q     = '{64'd7, 64'd8};
        exp_addr_q = '{40'h1000, 40'h1008};
        do_cmd(OP_SET_BASE, 64'h1000);
        do_cmd(OP_SET_STRIDE, 64'd8);
        do_cmd(OP_SET_COUNT, 64'd2);
        do_cmd(OP_START, 64'd0);
        repeat (4) @(negedge clk);
        check("pre_reset_busy", 64'(bus.busy), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_resp_val", 64'(bus.resp_val), 64'd0);
        check("mid_rst_resp_data", bus.resp_data, 64'd0);
        check("mid_rst_mem_req_val", 64'(bus.mem_req_val), 64'd0);
        check("mid_rst_transid", 64'(bus.mem_req_transid), 64'd0);
        check("mid_rst_addr", 64'(bus.mem_req_addr), 64'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        mem_mode = 2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("late_resp_val", 64'(bus.resp_val), 64'd0);
        end
        check("late_drained", 64'(pend.size()), 64'd0);
        mem_mode = 0;
        @(posedge clk);
        #1;
        exp_resp_q.push_back(64'd0);
        do_cmd(OP_READ_COUNT, 64'd0);
        wait_done("post_rst_count");

        data_q     = '{64'd4, 64'd5, 64'd6};
        exp_addr_q = '{40'h2000, 40'h2008, 40'h2010};
        exp_resp_q.push_back(64'd15);
        do_cmd(OP_SET_BASE, 64'h2000);
        do_cmd(OP_SET_STRIDE, 64'd8);
        do_cmd(OP_SET_COUNT, 64'd3);
        do_cmd(OP_START, 64'd0);
        wait_done("post_rst_job");
        check("final_addrs_left", 64'(exp_addr_q.size()), 64'd0);
        check("final_data_left", 64'(data_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tight_acc_reduce.md
TIGHT_ACC_REDUCE -- requirements
Module: tight_acc_reduce

Interface
REQ-001 Parameter MAX_INFLIGHT, default 8: maximum outstanding memory requests; power of 2, range 1..64.
REQ-002 Parameter CNT_W, default 16: width of the element-count register.
REQ-003 Port clk  in  1  sole clock; all state on rising edge.
REQ-004 Port rst  in  1  reset, asynchronous, active-high.
REQ-005 Ports cmd_val in 1, busy out 1, cmd_opcode in 6, cmd_config_data in 64: command channel; accepted when cmd_val && !busy.
REQ-006 Ports resp_val out 1, resp_rdy in 1, resp_data out 64: result channel to core.
REQ-007 Ports mem_req_rdy in 1, mem_req_val out 1, mem_req_transid out 6, mem_req_addr out DCP_PADDR width: load requests to L2.
REQ-008 Ports mem_resp_val in 1, mem_resp_transid in 6, mem_resp_data in DCP_NOC_RES_DATA_SIZE: load responses; element = mem_resp_data[63:0].

Function
REQ-009 Opcodes SHALL be: 0 SET_BASE, 1 SET_STRIDE, 2 SET_COUNT, 3 START, 4 READ_COUNT, 5 READ_CYCLES (macro only); all others accepted and ignored.
REQ-010 SET_* SHALL write base (PADDR bits), stride (64b, bytes), count (CNT_W low bits) in the accept cycle; no response.
REQ-011 FSM SHALL have states IDLE, ISSUE, DRAIN, RESP; busy = (state != IDLE).
REQ-012 START SHALL clear sum, load running address = base, issue index = 0, go ISSUE; if count == 0 go directly RESP with result 0.
REQ-013 In ISSUE, mem_req_val SHALL be high while outstanding < MAX_INFLIGHT; transid = issue index mod MAX_INFLIGHT; addr = running address.
REQ-014 On mem_req_val && mem_req_rdy, address SHALL advance by stride, modulo 2^PADDR width (wrap, no error); index increments.
REQ-015 After final issue handshake, FSM SHALL enter DRAIN; from DRAIN enter RESP when outstanding reaches 0.
REQ-016 mem_resp_val with transid marked outstanding SHALL add element to 64-bit sum (wrap modulo 2^64) and clear the mark; unmarked transids SHALL be ignored.
REQ-017 Same-cycle issue and response SHALL leave outstanding count unchanged; same-slot set and clear impossible by construction.
REQ-018 Responses may arrive out of order; result is order-independent.
REQ-019 READ_COUNT SHALL go RESP next cycle with resp_data = zero-extended count.
REQ-020 In RESP, resp_val held high with stable resp_data until resp_rdy; handshake returns to IDLE.
REQ-021 Minimum latency START to resp_val for count=1, zero-wait memory: 3 cycles.

Reset
REQ-022 On rst: state IDLE, busy 0, resp_val 0, resp_data 0, mem_req_val 0, transid 0, addr 0, outstanding bitmap/count 0, config registers 0.
REQ-023 Reset mid-operation SHALL abandon the job; memory responses arriving after reset SHALL be ignored (bitmap clear).

Configuration
REQ-024 Macro TIGHT_ACC_REDUCE_PERF_EN defined: 32-bit cycle counter counts cycles in ISSUE/DRAIN of last job, cleared on START; READ_CYCLES returns it zero-extended.
REQ-025 Macro undefined: counter absent; opcode 5 ignored like any unknown opcode.

Structure
REQ-026 Package tight_acc_pkg SHALL hold opcode enum, FSM state typedef, opcode width constant.
REQ-027 Sub-module tight_acc_txn_tracker SHALL hold outstanding bitmap, outstanding count, full/empty flags.

Verification
REQ-028 SET_BASE 0x1000, SET_STRIDE 8, SET_COUNT 4, START, data 1,2,3,4 in order -> addrs 0x1000/08/10/18, resp_data 10.
REQ-029 MAX_INFLIGHT=2, count 5, memory withholds responses -> at most 2 outstanding, mem_req_val low while full; releases reversed -> resp_data correct sum.
REQ-030 SET_COUNT 0, START -> resp_val next cycle, resp_data 0, no mem_req_val.
REQ-031 Stray mem_resp transid 7 in IDLE and duplicate transid during job -> sum unaffected; resp_rdy low 5 cycles -> resp_val/resp_data stable.
REQ-032 rst asserted mid-DRAIN, then late responses -> all outputs reset values, no resp_val; next job correct.
REQ-033 PERF_EN: count 2, mem_req_rdy stalled 3 cycles -> READ_CYCLES reports ISSUE+DRAIN cycles exactly; without macro opcode 5 gives no response.
